// File: rtl/ps2_keyboard_tx_pkg.sv
// Shared PS/2 definitions: transmitter states, frame size, scan-code prefixes, frame builder.
package ps2_keyboard_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        GAP  = 2'd3
    } tx_state_t;

    localparam int         PS2_FRAME_BITS = 11;
    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;

    // Bit 0 goes out first: start(0), data LSB first, odd parity, stop(1).
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Scan-code byte queue: peek-head read, count-based flags, sticky overflow on a write while full.
module ps2_tx_fifo
    import ps2_keyboard_tx_pkg::*;
#(
    parameter int FIFO_AW = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    logic [7:0]       mem [2**FIFO_AW];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               push;
    logic               do_pop;

    // count never exceeds the depth, so its top bit alone means full
    assign full   = count[FIFO_AW];
    assign empty  = (count == '0);
    assign push   = wr_en && !full;
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_keyboard_tx.sv
// PS/2 device-side transmitter: queues scan-code bytes and drives 11-bit frames on ps2_clk/ps2_data.
module ps2_keyboard_tx
    import ps2_keyboard_tx_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int GAP_CYCLES = 32,
    parameter int FIFO_AW    = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       host_inhibit,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow
);

    localparam int               HC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int               GC_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [HC_W-1:0]  HC_LAST = HC_W'(CLK_DIV - 1);
    localparam logic [GC_W-1:0]  GC_LAST = GC_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       BI_LAST = 4'(PS2_FRAME_BITS - 1);

    tx_state_t                 state, state_nxt;
    logic [HC_W-1:0]           hc, hc_nxt;
    logic [GC_W-1:0]           gc, gc_nxt;
    logic [3:0]                bi, bi_nxt;
    logic [PS2_FRAME_BITS-1:0] sr, sr_nxt;
    logic                      clk_r, clk_nxt;
    logic                      data_r, data_nxt;
    logic                      pop;
    logic [7:0]                head;

    ps2_tx_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .clrn     (clrn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    assign ps2_clk  = clk_r;
    assign ps2_data = data_r;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= IDLE;
            hc     <= '0;
            gc     <= '0;
            bi     <= '0;
            sr     <= '0;
            clk_r  <= 1'b1;
            data_r <= 1'b1;
        end else begin
            state  <= state_nxt;
            hc     <= hc_nxt;
            gc     <= gc_nxt;
            bi     <= bi_nxt;
            sr     <= sr_nxt;
            clk_r  <= clk_nxt;
            data_r <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hc_nxt    = hc;
        gc_nxt    = gc;
        bi_nxt    = bi;
        sr_nxt    = sr;
        clk_nxt   = clk_r;
        data_nxt  = data_r;
        pop       = 1'b0;

        case (state)
            IDLE: begin
                clk_nxt  = 1'b1;
                data_nxt = 1'b1;
                if (!empty && !host_inhibit) begin
                    sr_nxt    = ps2_frame(head);
                    data_nxt  = 1'b0;
                    bi_nxt    = '0;
                    hc_nxt    = '0;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (host_inhibit && bi < BI_LAST) begin
                    state_nxt = IDLE;
                    clk_nxt   = 1'b1;
                    data_nxt  = 1'b1;
                    hc_nxt    = '0;
                    bi_nxt    = '0;
                end else if (hc == HC_LAST) begin
                    clk_nxt   = 1'b0;
                    hc_nxt    = '0;
                    state_nxt = LOW;
                end else begin
                    hc_nxt = hc + 1'b1;
                end
            end
            LOW: begin
                // Once the stop bit has been sampled the frame is committed.
                if (host_inhibit && bi < BI_LAST) begin
                    state_nxt = IDLE;
                    clk_nxt   = 1'b1;
                    data_nxt  = 1'b1;
                    hc_nxt    = '0;
                    bi_nxt    = '0;
                end else if (hc == HC_LAST) begin
                    clk_nxt = 1'b1;
                    hc_nxt  = '0;
                    if (bi == BI_LAST) begin
                        data_nxt  = 1'b1;
                        pop       = 1'b1;
                        gc_nxt    = '0;
                        state_nxt = GAP;
                    end else begin
                        bi_nxt    = bi + 1'b1;
                        sr_nxt    = {1'b1, sr[PS2_FRAME_BITS-1:1]};
                        data_nxt  = sr[1];
                        state_nxt = HIGH;
                    end
                end else begin
                    hc_nxt = hc + 1'b1;
                end
            end
            GAP: begin
                clk_nxt  = 1'b1;
                data_nxt = 1'b1;
                if (gc == GC_LAST) begin
                    gc_nxt    = '0;
                    state_nxt = IDLE;
                end else begin
                    gc_nxt = gc + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ps2_keyboard_tx.sv
// Bench for ps2_keyboard_tx: frames are captured at ps2_clk falls and scored against hand-computed frames.
module tb_ps2_keyboard_tx;

    localparam int CLK_DIV    = 16;
    localparam int GAP_CYCLES = 32;
    localparam int FIFO_AW    = 3;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       host_inhibit = 1'b0;
    logic       ps2_clk;
    logic       ps2_data;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;
    int frames_seen = 0;
    logic [10:0] sb_q[$];

    ps2_keyboard_tx #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES),
        .FIFO_AW    (FIFO_AW)
    ) dut (
        .clk          (clk),
        .clrn         (clrn),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .host_inhibit (host_inhibit),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .full         (full),
        .empty        (empty),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Frames written out by hand, bit 0 = start bit, bit 10 = stop bit.
    function automatic logic [10:0] hand_frame(input logic [7:0] d);
        case (d)
            8'h1C:   return 11'h438;
            8'hF0:   return 11'h7E0;
            8'h00:   return 11'h600;
            8'h01:   return 11'h402;
            8'h02:   return 11'h404;
            8'h03:   return 11'h606;
            8'h04:   return 11'h408;
            8'h05:   return 11'h60A;
            8'h06:   return 11'h60C;
            8'h07:   return 11'h40E;
            8'h08:   return 11'h410;
            8'h55:   return 11'h6AA;
            default: return 11'h000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: shift in ps2_data at every ps2_clk fall, score each complete frame.
    logic [10:0] mon_bits = '0;
    int          mon_n    = 0;
    logic        mon_prev = 1'b1;
    logic [10:0] mon_exp;
    always @(negedge clk) begin
        if (!clrn || !busy) begin
            mon_n = 0;
        end else if (mon_prev && !ps2_clk) begin
            mon_bits[mon_n] = ps2_data;
            mon_n++;
            if (mon_n == 11) begin
                mon_n = 0;
                frames_seen++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got 0x%0h expected none", mon_bits);
                end else begin
                    mon_exp = sb_q.pop_front();
                    check("frame", {21'd0, mon_bits}, {21'd0, mon_exp});
                end
            end
        end
        mon_prev = ps2_clk;
    end

    task automatic write_one(input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        sb_q.push_back(hand_frame(d));
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busy || !empty) && k < budget);
        check(name, {31'd0, (busy || !empty)}, 32'd0);
    endtask

    task automatic wait_falls(input string name, input int n, input int budget);
        int k;
        int f;
        logic p;
        k = 0;
        f = 0;
        p = ps2_clk;
        while (f < n && k < budget) begin
            @(negedge clk);
            k++;
            if (p && !ps2_clk) f++;
            p = ps2_clk;
        end
        check(name, f, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int falls;
        int first_fall;
        int busy_cycles;
        int seen0;
        logic prev;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ps2_clk", ps2_clk, 1);
        check("rst_ps2_data", ps2_data, 1);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        clrn = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0x1C: latency, fall count, busy length
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'h1C;
        sb_q.push_back(hand_frame(8'h1C));
        @(negedge clk);
        wr_en = 1'b0;
        check("lat_empty", empty, 0);
        check("lat_data_pre", ps2_data, 1);
        @(negedge clk);
        check("lat_start_data", ps2_data, 0);
        check("lat_start_clk", ps2_clk, 1);
        check("lat_busy", busy, 1);
        k = 0;
        falls = 0;
        first_fall = -1;
        busy_cycles = 1;
        prev = ps2_clk;
        while (busy && k < 2000) begin
            @(negedge clk);
            k++;
            if (prev && !ps2_clk) begin
                falls++;
                if (first_fall < 0) first_fall = k;
            end
            prev = ps2_clk;
            if (busy) busy_cycles++;
        end
        check("busy_drop", busy, 0);
        check("first_fall", first_fall, CLK_DIV);
        check("fall_count", falls, 11);
        check("busy_cycles", busy_cycles, 22 * CLK_DIV + GAP_CYCLES);
        check("empty_after", empty, 1);
        check("q_single", sb_q.size(), 0);

        // Loopback sequence 0x1C, 0xF0, 0x1C written back-to-back
        seen0 = frames_seen;
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'h1C; sb_q.push_back(hand_frame(8'h1C));
        @(negedge clk);
        wr_data = 8'hF0; sb_q.push_back(hand_frame(8'hF0));
        @(negedge clk);
        wr_data = 8'h1C; sb_q.push_back(hand_frame(8'h1C));
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle("seq_idle", 3 * 500);
        check("seq_frames", frames_seen - seen0, 3);
        check("seq_q", sb_q.size(), 0);
        check("seq_overflow", overflow, 0);

        // Fill while inhibited: 8 accepted, 9th overflows
        host_inhibit = 1'b1;
        seen0 = frames_seen;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = 8'(i);
            if (i <= 8) sb_q.push_back(hand_frame(8'(i)));
            @(posedge clk);
            #1;
            if (i == 8) begin
                check("fill_full8", full, 1);
                check("fill_ovf8", overflow, 0);
            end
            if (i == 9) check("fill_ovf9", overflow, 1);
        end
        @(negedge clk);
        wr_en = 1'b0;
        repeat (40) @(negedge clk);
        check("inhibit_idle", busy, 0);
        check("inhibit_clk", ps2_clk, 1);
        host_inhibit = 1'b0;
        wait_idle("fill_idle", 8 * 500);
        check("fill_frames", frames_seen - seen0, 8);
        check("fill_q", sb_q.size(), 0);
        check("fill_ovf_sticky", overflow, 1);

        // Abort during bit 4 (LOW phase), then full resend
        seen0 = frames_seen;
        write_one(8'h00);
        wait_falls("abort_falls", 5, 500);
        repeat (3) @(negedge clk);
        host_inhibit = 1'b1;
        @(negedge clk);
        check("abort_clk", ps2_clk, 1);
        check("abort_data", ps2_data, 1);
        check("abort_busy", busy, 0);
        check("abort_empty", empty, 0);
        repeat (40) @(negedge clk);
        check("abort_hold", busy, 0);
        host_inhibit = 1'b0;
        wait_idle("abort_idle", 600);
        check("abort_frames", frames_seen - seen0, 1);
        check("abort_q", sb_q.size(), 0);

        // Asynchronous reset in bit 6
        write_one(8'h55);
        wait_falls("rst_falls", 7, 500);
        repeat (4) @(negedge clk);
        #2;
        clrn = 1'b0;
        #1;
        check("arst_clk", ps2_clk, 1);
        check("arst_data", ps2_data, 1);
        check("arst_empty", empty, 1);
        check("arst_overflow", overflow, 0);
        check("arst_busy", busy, 0);
        sb_q.delete();
        @(negedge clk);
        clrn = 1'b1;
        seen0 = frames_seen;
        write_one(8'h1C);
        wait_idle("post_rst_idle", 600);
        check("post_rst_frames", frames_seen - seen0, 1);
        check("post_rst_q", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
